nv_fifo_rws_ctrl_16x64: RTL and testbench
=========================================

# nv_fifo_rws_ctrl_16x64

Initiator-side controller for a 16x64 two-port registered-read-address RAM (`nv_ram_rws_16x64`). It drives the RAM's write port (`wa/we/di`) and read port (`ra/re`) and consumes `dout`, presenting a valid/ready FIFO to the datapath. A 2-entry output buffer hides the one-cycle RAM read latency and sustains one transfer per cycle. Total capacity is 18 entries: 16 in RAM plus 2 in the output buffer.

## Interface
- No parameters. Geometry is fixed: depth 16, width 64.
- `nvdla_core_clk  in  1` — clock.
- `nvdla_core_rstn  in  1` — reset. Asynchronous, active-low.
- `wr_pvld  in  1` — write data valid.
- `wr_prdy  out  1` — write ready.
- `wr_pd  in  64` — write payload.
- `rd_pvld  out  1` — read data valid.
- `rd_prdy  in  1` — read ready.
- `rd_pd  out  64` — read payload.
- `ram_wa  out  4` — RAM write address.
- `ram_we  out  1` — RAM write enable.
- `ram_di  out  64` — RAM write data.
- `ram_ra  out  4` — RAM read address.
- `ram_re  out  1` — RAM read enable.
- `ram_dout  in  64` — RAM read data. Valid in the cycle after `ram_re`.
- `pwrbus_ram_pd  in  32` — power bus.
- `ram_pwrbus_ram_pd  out  32` — direct pass-through of `pwrbus_ram_pd`.
- `fifo_level  out  5` — total occupancy, 0..18. Present only with `NV_FIFO_RWS_CTRL_LEVEL_EN`.

## Operation
- **State:** `wr_ptr[3:0]`, `rd_ptr[3:0]`, `ram_cnt[4:0]` (0..16), `inflight` (1 bit), 2-entry output buffer `ob[0..1]` with `ob_cnt[1:0]` (0..2).
- **Write accept:** `wr_acc = wr_pvld & wr_prdy`, with `wr_prdy = (ram_cnt != 16)` (combinational).
  - `ram_we = wr_acc`, `ram_wa = wr_ptr`, `ram_di = wr_pd`.
  - `wr_ptr` increments mod 16 on `wr_acc`.
- **Pop:** `pop = rd_pvld & rd_prdy`.
- **Read issue:** `ram_re = (ram_cnt != 0) & (ob_cnt + inflight - pop < 2)`, `ram_ra = rd_ptr`.
  - On issue, `rd_ptr` increments mod 16.
  - The slot is freed at issue: `ram_cnt` decrements at the same edge.
- **Capture:** `inflight <= ram_re`. While `inflight`, `ram_dout` is pushed into the output buffer at the cycle-end edge.
- **Write to a just-freed slot:** `ram_we` may target the slot being captured in the same cycle. The capture takes the old contents because the RAM write lands at the same edge. This case is legal.
- **Counter update:** `ram_cnt` next = `ram_cnt + wr_acc - ram_re`. Simultaneous accept and issue leaves the count unchanged.
- **Output:** `rd_pvld = (ob_cnt != 0)`, `rd_pd = ob[head]`.
  - Pop and capture in the same cycle keep `ob_cnt`.
  - Order is strict FIFO across RAM and buffer.
- **Wrap-around:** pointers wrap 15 → 0 silently. Full and empty are distinguished only by `ram_cnt`.
- **Overflow/underflow:** a write while full is blocked by `wr_prdy=0`. `ram_re` is never asserted while `ram_cnt == 0`.

## Timing
- **Reset values:**
  - `ram_cnt=0`, `wr_ptr=0`, `rd_ptr=0`, `inflight=0`, `ob_cnt=0`, `ob` contents 0.
  - `wr_prdy=1`, `rd_pvld=0`, `rd_pd=0`.
  - `ram_we=0`, `ram_re=0`, `ram_wa=0`, `ram_ra=0`.
- **Reset mid-operation:** all contents are discarded. No output is valid until new writes arrive.
- **Empty-FIFO latency:** write accepted in cycle t → `ram_re` in t+1 → captured end of t+2 → `rd_pvld=1` in t+3.
- **Throughput:** steady state is one accept and one pop per cycle, with `ob_cnt=1` and `inflight=1`.
- **`rd_pd` stability:** `rd_pd` is held stable while `rd_pvld & !rd_prdy`.

## Configuration
- **`NV_FIFO_RWS_CTRL_LEVEL_EN` defined:**
  - `fifo_level` port exists, registered, `= ram_cnt + inflight + ob_cnt`.
  - Reset value 0; reads 18 when completely full.
- **Not defined:** the port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- **Fill:** `rd_prdy=0`, write 0..19 back-to-back → exactly 18 accepted (values 0..17). `wr_prdy=0` from the cycle `ram_cnt` reaches 16 with `ob_cnt=2`. Then `rd_prdy=1` → reads 0..17 in order, `rd_pvld` drops after 17.
- **Latency:** single write `0xDEAD` at cycle t into an empty FIFO → `ram_re` at t+1, `rd_pvld=1` with `rd_pd=0xDEAD` at t+3.
- **Streaming and wrap:** `wr_pvld=1` and `rd_prdy=1` continuously for 100 words → one pop per cycle after fill-up, pointers wrap at least 6 times, data in order, no `wr_prdy` drop.
- **Backpressure:** random `rd_prdy` toggling over 500 random words → `rd_pd` held stable while stalled, no loss or duplication, `ram_re` never asserted with `ram_cnt==0`.
- **Reset mid-operation:** assert `nvdla_core_rstn=0` asynchronously with 10 entries queued → `rd_pvld=0` and `wr_prdy=1` immediately. After release, write 0x55 → read 0x55 only.
- **Level:** with `NV_FIFO_RWS_CTRL_LEVEL_EN`, write 5 entries with no reads → `fifo_level=5` once settled; at full, `fifo_level=18`.

Source files
------------

// File: rtl/nv_fifo_rws_ctrl_16x64.sv
// nv_fifo_rws_ctrl_16x64
// Initiator-side controller for a 16x64 registered-read RAM. It presents a
// valid/ready FIFO of 18 entries: 16 in RAM and 2 in a small output buffer
// that hides the one-cycle RAM read latency.
//
// Handshake: a transfer happens on a side in any cycle where valid and ready
// are both high at the rising clock edge. wr_prdy depends only on state.
// rd_pvld/rd_pd depend only on state, and rd_pd is stable while the read
// side is stalled (rd_pvld & !rd_prdy).
//
// Optional build macro: NV_FIFO_RWS_CTRL_LEVEL_EN adds the registered
// fifo_level output (total occupancy, 0..18).
module nv_fifo_rws_ctrl_16x64 (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [63:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [63:0] rd_pd,
    output logic [3:0]  ram_wa,
    output logic        ram_we,
    output logic [63:0] ram_di,
    output logic [3:0]  ram_ra,
    output logic        ram_re,
    input  logic [63:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd
`ifdef NV_FIFO_RWS_CTRL_LEVEL_EN
    ,
    output logic [4:0]  fifo_level
`endif
);

    logic [3:0]  wr_ptr_q,   wr_ptr_d;
    logic [3:0]  rd_ptr_q,   rd_ptr_d;
    logic [4:0]  ram_cnt_q,  ram_cnt_d;
    logic        inflight_q, inflight_d;
    logic [63:0] ob0_q,      ob0_d;
    logic [63:0] ob1_q,      ob1_d;
    logic        ob_head_q,  ob_head_d;
    logic [1:0]  ob_cnt_q,   ob_cnt_d;

    logic        wr_acc;
    logic        pop;
    logic [2:0]  ob_occ;
    logic        ob_tail;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    // Handshakes, RAM port drive and read-issue decision.
    always_comb begin
        wr_prdy = (ram_cnt_q != 5'd16);
        wr_acc  = wr_pvld & wr_prdy;
        rd_pvld = (ob_cnt_q != 2'd0);
        rd_pd   = ob_head_q ? ob1_q : ob0_q;
        pop     = rd_pvld & rd_prdy;
        // Buffer slots already spoken for: held entries plus the read in flight.
        ob_occ  = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
        // Issue only when the returning word is guaranteed a free buffer slot.
        ram_re  = (ram_cnt_q != 5'd0) && (ob_occ < (3'd2 + {2'b00, pop}));
        ram_we  = wr_acc;
        ram_wa  = wr_ptr_q;
        ram_di  = wr_pd;
        ram_ra  = rd_ptr_q;
    end

    // Next-state for pointers, RAM occupancy and the output buffer.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {3'b000, wr_acc};
        rd_ptr_d   = rd_ptr_q + {3'b000, ram_re};
        // The RAM slot is released at issue, so a write may reuse it at once.
        ram_cnt_d  = ram_cnt_q + {4'b0000, wr_acc} - {4'b0000, ram_re};
        inflight_d = ram_re;
        // At capture time ob_cnt is at most 1, so the tail slot is always free.
        ob_tail    = ob_head_q ^ ob_cnt_q[0];
        ob0_d      = ob0_q;
        ob1_d      = ob1_q;
        if (inflight_q) begin
            if (ob_tail) begin
                ob1_d = ram_dout;
            end else begin
                ob0_d = ram_dout;
            end
        end
        ob_head_d  = ob_head_q ^ pop;
        ob_cnt_d   = ob_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // State registers; reset discards all queued contents.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q   <= 4'd0;
            rd_ptr_q   <= 4'd0;
            ram_cnt_q  <= 5'd0;
            inflight_q <= 1'b0;
            ob0_q      <= 64'd0;
            ob1_q      <= 64'd0;
            ob_head_q  <= 1'b0;
            ob_cnt_q   <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
            ob_head_q  <= ob_head_d;
            ob_cnt_q   <= ob_cnt_d;
        end
    end

`ifdef NV_FIFO_RWS_CTRL_LEVEL_EN
    logic [4:0] fifo_level_q, fifo_level_d;

    // Total occupancy after this edge: RAM + read in flight + buffer.
    always_comb begin
        fifo_level_d = ram_cnt_d + {4'b0000, inflight_d} + {3'b000, ob_cnt_d};
    end

    // Registered occupancy output.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            fifo_level_q <= 5'd0;
        end else begin
            fifo_level_q <= fifo_level_d;
        end
    end

    assign fifo_level = fifo_level_q;
`endif

endmodule

// File: tb/tb_nv_fifo_rws_ctrl_16x64.sv
// Testbench for nv_fifo_rws_ctrl_16x64 with a behavioural 16x64 RAM model.
module tb_nv_fifo_rws_ctrl_16x64;

  logic        clk;
  logic        rst_n;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [63:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [63:0] rd_pd;
  logic [3:0]  ram_wa;
  logic        ram_we;
  logic [63:0] ram_di;
  logic [3:0]  ram_ra;
  logic        ram_re;
  logic [63:0] ram_dout;
  logic [31:0] pwrbus_ram_pd;
  logic [31:0] ram_pwrbus_ram_pd;
`ifdef NV_FIFO_RWS_CTRL_LEVEL_EN
  logic [4:0]  fifo_level;
`endif

  nv_fifo_rws_ctrl_16x64 dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rst_n),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .ram_wa            (ram_wa),
    .ram_we            (ram_we),
    .ram_di            (ram_di),
    .ram_ra            (ram_ra),
    .ram_re            (ram_re),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
`ifdef NV_FIFO_RWS_CTRL_LEVEL_EN
    ,
    .fifo_level        (fifo_level)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: registered read, old data on same-edge write
  logic [63:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    ram_dout = 64'd0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          n_tests;
  int          n_fail;
  int          n_acc;
  int          n_pop;
  int          tb_ram_cnt;
  logic        prev_stall;
  logic [63:0] prev_pd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive at negedge, sample 1 time unit later.
  task automatic cycle(input logic wv, input logic [63:0] wd, input logic rr);
    logic [63:0] e;
    @(negedge clk);
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rr;
    #1;
    if (prev_stall) begin
      chk("hold_vld", {63'd0, rd_pvld}, 64'd1);
      chk("hold_pd", rd_pd, prev_pd);
    end
    chk("wr_prdy_model", {63'd0, wr_prdy}, {63'd0, (tb_ram_cnt != 16)});
    if (ram_re) chk("re_nonempty", {63'd0, (tb_ram_cnt != 0)}, 64'd1);
    if (wr_pvld && wr_prdy) begin
      exp_q.push_back(wd);
      n_acc++;
    end
    if (rd_pvld && rd_prdy) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_extra: got %h expected no data", rd_pd);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_pd, e);
      end
    end
    prev_stall = rd_pvld && !rd_prdy;
    prev_pd    = rd_pd;
    tb_ram_cnt = tb_ram_cnt + int'(ram_we) - int'(ram_re);
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n   = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    wr_pd   = 64'd0;
    #1;
    chk("rst_wr_prdy", {63'd0, wr_prdy}, 64'd1);
    chk("rst_rd_pvld", {63'd0, rd_pvld}, 64'd0);
    chk("rst_rd_pd", rd_pd, 64'd0);
    chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
    chk("rst_ram_re", {63'd0, ram_re}, 64'd0);
    chk("rst_ram_wa", {60'd0, ram_wa}, 64'd0);
    chk("rst_ram_ra", {60'd0, ram_ra}, 64'd0);
`ifdef NV_FIFO_RWS_CTRL_LEVEL_EN
    chk("rst_level", {59'd0, fifo_level}, 64'd0);
`endif
    exp_q.delete();
    tb_ram_cnt = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || rd_pvld); i++) cycle(1'b0, 64'd0, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_vld", {63'd0, rd_pvld}, 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wv;
    logic [63:0] wd;
    logic        rr;
    logic        exp_wrdy;
    logic        exp_rvld;
    logic [63:0] exp_rpd;
    logic        exp_re;
    logic        exp_we;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [63:0] wd, input logic rr,
                              input logic wrdy, input logic rvld, input logic [63:0] rpd,
                              input logic re, input logic we);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr;
    v.exp_wrdy = wrdy; v.exp_rvld = rvld; v.exp_rpd = rpd;
    v.exp_re = re; v.exp_we = we;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    int start, p0, stalls;
    n_tests = 0; n_fail = 0; n_acc = 0; n_pop = 0;
    tb_ram_cnt = 0; prev_stall = 1'b0; prev_pd = 64'd0;
    rst_n = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = 64'd0;
    pwrbus_ram_pd = 32'hA5A5_1234;

    // Latency of a single word, then a short burst with a stall.
    //            wv    wd            rr    wrdy  rvld  rpd           re    we
    vecs[0]  = mk(1'b1, 64'hDEAD,     1'b0, 1'b1, 1'b0, 64'd0,        1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'd0,        1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 64'd0,        1'b0, 1'b1, 1'b0, 64'd0,        1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 64'd0,        1'b1, 1'b1, 1'b1, 64'hDEAD,     1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 64'h11,       1'b0, 1'b1, 1'b0, 64'd0,        1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 64'h22,       1'b0, 1'b1, 1'b0, 64'd0,        1'b1, 1'b1);
    vecs[6]  = mk(1'b1, 64'h33,       1'b0, 1'b1, 1'b0, 64'd0,        1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 64'd0,        1'b0, 1'b1, 1'b1, 64'h11,       1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 64'd0,        1'b0, 1'b1, 1'b1, 64'h11,       1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 64'd0,        1'b1, 1'b1, 1'b1, 64'h11,       1'b1, 1'b0);
    vecs[10] = mk(1'b0, 64'd0,        1'b1, 1'b1, 1'b1, 64'h22,       1'b0, 1'b0);
    vecs[11] = mk(1'b0, 64'd0,        1'b1, 1'b1, 1'b1, 64'h33,       1'b0, 1'b0);
    vecs[12] = mk(1'b0, 64'd0,        1'b1, 1'b1, 1'b0, 64'd0,        1'b0, 1'b0);

    do_reset();
    chk("pwrbus", {32'd0, ram_pwrbus_ram_pd}, 64'hA5A5_1234);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].wv, vecs[i].wd, vecs[i].rr);
      chk($sformatf("vec%0d_wr_prdy", i), {63'd0, wr_prdy}, {63'd0, vecs[i].exp_wrdy});
      chk($sformatf("vec%0d_rd_pvld", i), {63'd0, rd_pvld}, {63'd0, vecs[i].exp_rvld});
      if (vecs[i].exp_rvld) chk($sformatf("vec%0d_rd_pd", i), rd_pd, vecs[i].exp_rpd);
      chk($sformatf("vec%0d_ram_re", i), {63'd0, ram_re}, {63'd0, vecs[i].exp_re});
      chk($sformatf("vec%0d_ram_we", i), {63'd0, ram_we}, {63'd0, vecs[i].exp_we});
    end
    drain();

    // Fill: 20 offered with reads blocked, 18 accepted.
    do_reset();
    start = n_acc;
    for (int i = 0; i < 20; i++) cycle(1'b1, 64'(i), 1'b0);
    chk("fill_accepted", 64'(n_acc - start), 64'd18);
    repeat (3) cycle(1'b0, 64'd0, 1'b0);
    chk("fill_wr_prdy", {63'd0, wr_prdy}, 64'd0);
    chk("fill_rd_pvld", {63'd0, rd_pvld}, 64'd1);
    chk("fill_head", rd_pd, 64'd0);
    p0 = n_pop;
    drain();
    chk("fill_pops", 64'(n_pop - p0), 64'd18);

    // Streaming: 100 words, one pop per cycle once primed, pointers wrap.
    do_reset();
    start = n_acc; p0 = n_pop; stalls = 0;
    for (int i = 0; i < 400 && (n_acc - start) < 100; i++) begin
      cycle(1'b1, 64'h1000 + 64'(n_acc - start), 1'b1);
      if (!wr_prdy) stalls++;
    end
    chk("stream_accepted", 64'(n_acc - start), 64'd100);
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_pops", 64'(n_pop - p0), 64'd97);
    drain();

    // Backpressure: 500 random words with random read stalls.
    start = n_acc;
    for (int i = 0; i < 5000 && (n_acc - start) < 500; i++)
      cycle(1'($urandom_range(0, 1)), 64'h2000 + 64'(n_acc - start), 1'($urandom_range(0, 1)));
    chk("bp_accepted", 64'(n_acc - start), 64'd500);
    drain();

    // Reset with 10 entries queued, then a single fresh word.
    for (int i = 0; i < 10; i++) cycle(1'b1, 64'h3000 + 64'(i), 1'b0);
    do_reset();
    p0 = n_pop;
    cycle(1'b1, 64'h55, 1'b0);
    drain();
    chk("post_rst_pops", 64'(n_pop - p0), 64'd1);

`ifdef NV_FIFO_RWS_CTRL_LEVEL_EN
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h4000 + 64'(i), 1'b0);
    repeat (4) cycle(1'b0, 64'd0, 1'b0);
    chk("level_5", {59'd0, fifo_level}, 64'd5);
    for (int i = 0; i < 20; i++) cycle(1'b1, 64'h4100 + 64'(i), 1'b0);
    repeat (3) cycle(1'b0, 64'd0, 1'b0);
    chk("level_full", {59'd0, fifo_level}, 64'd18);
    drain();
    cycle(1'b0, 64'd0, 1'b0);
    chk("level_empty", {59'd0, fifo_level}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
